// File: rtl/mips_pkg.sv
// Shared MIPS core package.
// Holds the default datapath widths, the writeback-select encodings and the
// control bundle the decoder hands to the execute/writeback stages.
package mips_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_RADDR = 5;

  // Writeback data source select. Encoding 3 is reserved and decodes as ALU.
  localparam logic [1:0] REGSEL_ALU = 2'd0;
  localparam logic [1:0] REGSEL_HI  = 2'd1;
  localparam logic [1:0] REGSEL_LO  = 2'd2;

  // Control bundle emitted by the decoder.
  typedef struct packed {
    logic [1:0] regsel;       // writeback data source
    logic       enhilo;       // mult/multu: latch HI/LO
    logic       regwrite;     // instruction writes a GPR
    logic       gpio_out_en;  // GPIO write instruction
  } ctrl_t;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair.
// Ports:
//   clk, rst      - clock, async active-low reset (clears both halves)
//   en            - load hi_d/lo_d on the rising edge
//   hi_d, lo_d    - next HI / LO values
//   hi_q, lo_q    - current HI / LO values
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] hi_d,
  input  logic [WIDTH-1:0] lo_d,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (en) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Execute-to-writeback pipeline stage.
// Registers the EX control bundle and result into WB, owns HI/LO and the
// GPIO output register, and drives the register-file write port.
// Ports:
//   clk, rst                 - clock, async active-low reset
//   stall, flush             - hold stage / replace EX instruction by a bubble
//   regsel_EX .. gpio_data_EX - EX-stage control bundle and datapath results
//   regwrite_WB, writeaddr_WB, writedata_WB - register-file write port
//   hi_q, lo_q               - architectural HI / LO
//   gpio_out                 - GPIO output pins
module writeback_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RADDR = DEF_RADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       regsel_EX,
  input  logic             enhilo_EX,
  input  logic             regwrite_EX,
  input  logic             gpio_out_en_EX,
  input  logic [RADDR-1:0] writeaddr_EX,
  input  logic [WIDTH-1:0] alu_lo_EX,
  input  logic [WIDTH-1:0] alu_hi_EX,
  input  logic [WIDTH-1:0] gpio_data_EX,
  output logic             regwrite_WB,
  output logic [RADDR-1:0] writeaddr_WB,
  output logic [WIDTH-1:0] writedata_WB,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic [WIDTH-1:0] gpio_out
);

  ctrl_t            ctrl_ex;
  logic             advance;  // WB pipeline register loads (real op or bubble)
  logic             commit;   // a real instruction leaves EX this edge
  logic [WIDTH-1:0] wdata_ex;

  assign ctrl_ex = '{regsel:      regsel_EX,
                     enhilo:      enhilo_EX,
                     regwrite:    regwrite_EX,
                     gpio_out_en: gpio_out_en_EX};

  // Flush wins over stall: a flushed cycle still advances, carrying a bubble.
  assign advance = flush | ~stall;
  assign commit  = ~flush & ~stall;

  // Selected from the pre-edge HI/LO. A mult directly ahead has already
  // updated HI/LO on the edge it left EX, so no bypass is needed.
  always_comb begin
    wdata_ex = alu_lo_EX;
    case (ctrl_ex.regsel)
      REGSEL_HI: wdata_ex = hi_q;
      REGSEL_LO: wdata_ex = lo_q;
      default:   wdata_ex = alu_lo_EX;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwrite_WB  <= 1'b0;
      writeaddr_WB <= '0;
      writedata_WB <= '0;
    end else if (advance) begin
      if (flush) begin
        regwrite_WB  <= 1'b0;
        writeaddr_WB <= '0;
        writedata_WB <= '0;
      end else begin
        // $0 is hardwired: never enable a write to it.
        regwrite_WB  <= ctrl_ex.regwrite && (writeaddr_EX != '0);
        writeaddr_WB <= writeaddr_EX;
        writedata_WB <= wdata_ex;
      end
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .en   (commit & ctrl_ex.enhilo),
    .hi_d (alu_hi_EX),
    .lo_d (alu_lo_EX),
    .hi_q (hi_q),
    .lo_q (lo_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               gpio_out <= '0;
    else if (commit && ctrl_ex.gpio_out_en) gpio_out <= gpio_data_EX;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vectors with literal
// expectations plus a transaction-level model compared on every negedge.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic [1:0]  regsel_EX;
  logic        enhilo_EX, regwrite_EX, gpio_out_en_EX;
  logic [4:0]  writeaddr_EX;
  logic [31:0] alu_lo_EX, alu_hi_EX, gpio_data_EX;
  logic        regwrite_WB;
  logic [4:0]  writeaddr_WB;
  logic [31:0] writedata_WB, hi_q, lo_q, gpio_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_unit #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .regsel_EX(regsel_EX), .enhilo_EX(enhilo_EX), .regwrite_EX(regwrite_EX),
    .gpio_out_en_EX(gpio_out_en_EX), .writeaddr_EX(writeaddr_EX),
    .alu_lo_EX(alu_lo_EX), .alu_hi_EX(alu_hi_EX), .gpio_data_EX(gpio_data_EX),
    .regwrite_WB(regwrite_WB), .writeaddr_WB(writeaddr_WB),
    .writedata_WB(writedata_WB), .hi_q(hi_q), .lo_q(lo_q), .gpio_out(gpio_out)
  );

  // ---------------- architectural model ----------------
  // Each edge retires the EX instruction: a flush retires nothing (bubble),
  // a stall freezes everything, otherwise the instruction's effects apply.
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_hi, m_lo, m_gpio;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rw = 0; m_wa = 0; m_wd = 0; m_hi = 0; m_lo = 0; m_gpio = 0;
    end else if (flush) begin
      m_rw = 0; m_wa = 0; m_wd = 0;
    end else if (!stall) begin
      m_wd = (regsel_EX == 2'd1) ? m_hi : (regsel_EX == 2'd2) ? m_lo : alu_lo_EX;
      m_wa = writeaddr_EX;
      m_rw = regwrite_EX && (writeaddr_EX != 0);
      if (enhilo_EX) begin m_hi = alu_hi_EX; m_lo = alu_lo_EX; end
      if (gpio_out_en_EX) m_gpio = gpio_data_EX;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (regwrite_WB !== m_rw || writeaddr_WB !== m_wa || writedata_WB !== m_wd ||
        hi_q !== m_hi || lo_q !== m_lo || gpio_out !== m_gpio) begin
      failures++;
      $display("FAIL model t=%0t got rw=%0b wa=%0d wd=%h hi=%h lo=%h gpio=%h exp rw=%0b wa=%0d wd=%h hi=%h lo=%h gpio=%h",
               $time, regwrite_WB, writeaddr_WB, writedata_WB, hi_q, lo_q, gpio_out,
               m_rw, m_wa, m_wd, m_hi, m_lo, m_gpio);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one EX bundle, let one edge pass, return 2 time units after it.
  task automatic issue(input logic [1:0] rs, input logic eh, input logic rw, input logic ge,
                       input logic [4:0] wa, input logic [31:0] lo, input logic [31:0] hi,
                       input logic [31:0] gd, input logic st, input logic fl);
    regsel_EX = rs; enhilo_EX = eh; regwrite_EX = rw; gpio_out_en_EX = ge;
    writeaddr_EX = wa; alu_lo_EX = lo; alu_hi_EX = hi; gpio_data_EX = gd;
    stall = st; flush = fl;
    @(posedge clk); #2;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_rw"},   {31'd0, regwrite_WB}, 32'd0);
    chk({name, "_wa"},   {27'd0, writeaddr_WB}, 32'd0);
    chk({name, "_wd"},   writedata_WB, 32'd0);
    chk({name, "_hi"},   hi_q, 32'd0);
    chk({name, "_lo"},   lo_q, 32'd0);
    chk({name, "_gpio"}, gpio_out, 32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    regsel_EX = 2'($urandom); enhilo_EX = 1'b1; regwrite_EX = 1'b1; gpio_out_en_EX = 1'b1;
    writeaddr_EX = 5'($urandom); alu_lo_EX = $urandom; alu_hi_EX = $urandom;
    gpio_data_EX = $urandom; stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk_zero("reset");
    rst = 1'b1;

    // ADD rd=8 <- 7
    issue(2'd0, 0, 1, 0, 5'd8, 32'h7, 32'h0, 32'h0, 0, 0);
    chk("add_rw", {31'd0, regwrite_WB}, 32'd1);
    chk("add_wa", {27'd0, writeaddr_WB}, 32'd8);
    chk("add_wd", writedata_WB, 32'd7);

    // mult -> mfhi -> mflo back to back
    issue(2'd0, 1, 0, 0, 5'd0, 32'h9ABC_DEF0, 32'h1234_5678, 32'h0, 0, 0);
    chk("mult_rw", {31'd0, regwrite_WB}, 32'd0);
    chk("mult_hi", hi_q, 32'h1234_5678);
    chk("mult_lo", lo_q, 32'h9ABC_DEF0);
    issue(2'd1, 0, 1, 0, 5'd3, 32'hDEAD_0001, 32'h0, 32'h0, 0, 0);
    chk("mfhi_wd", writedata_WB, 32'h1234_5678);
    chk("mfhi_wa", {27'd0, writeaddr_WB}, 32'd3);
    issue(2'd2, 0, 1, 0, 5'd4, 32'hDEAD_0002, 32'h0, 32'h0, 0, 0);
    chk("mflo_wd", writedata_WB, 32'h9ABC_DEF0);
    chk("mflo_rw", {31'd0, regwrite_WB}, 32'd1);

    // write to $0 is suppressed
    issue(2'd0, 0, 1, 0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0);
    chk("r0_rw", {31'd0, regwrite_WB}, 32'd0);

    // GPIO write then five ordinary instructions
    issue(2'd0, 0, 0, 1, 5'd0, 32'h0, 32'h0, 32'hA5, 0, 0);
    chk("gpio_set", gpio_out, 32'hA5);
    for (int i = 1; i <= 5; i++) begin
      issue(2'd0, 0, 1, 0, 5'(i), 32'(i), 32'h0, 32'h5A, 0, 0);
      chk("gpio_hold", gpio_out, 32'hA5);
    end

    // mult (hi=1, lo=2) stalled for three cycles
    for (int i = 0; i < 3; i++) begin
      issue(2'd0, 1, 0, 0, 5'd0, 32'h2, 32'h1, 32'h0, 1, 0);
      chk("stall_hi", hi_q, 32'h1234_5678);
      chk("stall_lo", lo_q, 32'h9ABC_DEF0);
      chk("stall_wd", writedata_WB, 32'd5);
      chk("stall_wa", {27'd0, writeaddr_WB}, 32'd5);
      chk("stall_rw", {31'd0, regwrite_WB}, 32'd1);
    end
    issue(2'd0, 1, 0, 0, 5'd0, 32'h2, 32'h1, 32'h0, 0, 0);
    chk("unstall_hi", hi_q, 32'h1);
    chk("unstall_lo", lo_q, 32'h2);
    chk("unstall_rw", {31'd0, regwrite_WB}, 32'd0);

    // flush wins over stall: bubble, HI/LO untouched
    issue(2'd0, 1, 1, 1, 5'd7, 32'h88, 32'h77, 32'h33, 1, 1);
    chk("flush_rw", {31'd0, regwrite_WB}, 32'd0);
    chk("flush_wa", {27'd0, writeaddr_WB}, 32'd0);
    chk("flush_wd", writedata_WB, 32'd0);
    chk("flush_hi", hi_q, 32'h1);
    chk("flush_lo", lo_q, 32'h2);
    chk("flush_gpio", gpio_out, 32'hA5);

    // degenerate enhilo + regsel=HI: old HI written back, HI/LO still update
    issue(2'd1, 1, 1, 0, 5'd9, 32'hBBB, 32'hAAA, 32'h0, 0, 0);
    chk("degen_wd", writedata_WB, 32'h1);
    chk("degen_hi", hi_q, 32'hAAA);
    chk("degen_lo", lo_q, 32'hBBB);

    // async reset between edges after HI=5
    issue(2'd0, 1, 0, 0, 5'd0, 32'h6, 32'h5, 32'h0, 0, 0);
    chk("pre_rst_hi", hi_q, 32'h5);
    rst = 1'b0;
    #1 chk_zero("async_rst");
    #1 rst = 1'b1;
    issue(2'd0, 0, 1, 0, 5'd8, 32'h42, 32'h0, 32'h0, 0, 0);
    chk("post_rst_wd", writedata_WB, 32'h42);
    chk("post_rst_rw", {31'd0, regwrite_WB}, 32'd1);
    chk("post_rst_hi", hi_q, 32'h0);

    // mixed traffic checked against the model only
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end

    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Execute-to-writeback stage of the pipelined MIPS core; it consumes the control bundle the decoder emits (regsel, enhilo, regwrite, GPIO enable) along with the datapath results. It registers that bundle into the WB stage and owns the architectural HI/LO registers and the GPIO output register. It drives the register-file write port.

## Interface
- `WIDTH`, 32: datapath width.
- `RADDR`, 5: register address width.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `stall` in 1: hold all WB-side state.
- `flush` in 1: replace the current EX instruction with a bubble.
- `regsel_EX` in 2: 0 = ALU result, 1 = mfhi, 2 = mflo, 3 = reserved.
- `enhilo_EX` in 1: mult/multu, latch HI/LO.
- `regwrite_EX` in 1: instruction writes a GPR.
- `gpio_out_en_EX` in 1: GPIO write instruction.
- `writeaddr_EX` in RADDR: destination GPR.
- `alu_lo_EX` in WIDTH: ALU result, or low product half.
- `alu_hi_EX` in WIDTH: high product half.
- `gpio_data_EX` in WIDTH: rt operand value for the GPIO write.
- `regwrite_WB` out 1: register-file write enable.
- `writeaddr_WB` out RADDR: register-file write address.
- `writedata_WB` out WIDTH: register-file write data.
- `hi_q`, `lo_q` out WIDTH: architectural HI and LO.
- `gpio_out` out WIDTH: GPIO output pins.

## Operation
- Pipeline register: on each edge with `stall`=0, capture the EX bundle into WB. `writedata_WB` is registered, not combinational.
- Writeback data mux, evaluated in EX from current register values:
  - regsel 0 or 3: `alu_lo_EX`.
  - regsel 1: `hi_q`.
  - regsel 2: `lo_q`.
- HI/LO update: when `enhilo_EX`=1 and the stage advances, `hi_q`<=`alu_hi_EX` and `lo_q`<=`alu_lo_EX`.
- A mult followed immediately by mfhi/mflo sees the new value, because HI/LO update on the same edge the mult leaves EX. No bypass is needed.
- GPIO: when `gpio_out_en_EX`=1 and the stage advances, `gpio_out`<=`gpio_data_EX`. The value holds until the next GPIO write.
- $0 protection: `regwrite_WB` is forced to 0 when `writeaddr_EX`==0.
- Flush: capture a bubble: `regwrite_WB`=0, and HI/LO and GPIO are not updated. `writeaddr_WB`/`writedata_WB` are don't-care but must be driven to 0.
- Stall: WB registers, HI/LO and GPIO all hold.
- Priority when both asserted: flush > stall (a flushed cycle still advances to a bubble).
- Degenerate bundle with enhilo=1 and regsel≠0: data selects the pre-update HI/LO and HI/LO still update. Verification must not flag this.

## Timing
- Latency: an EX-cycle instruction appears on the WB outputs 1 cycle later.
- HI/LO and GPIO are visible 1 cycle after EX.
- While `rst`=0 (immediately, asynchronously), all outputs and state are 0: `regwrite_WB`, `writeaddr_WB`, `writedata_WB`, `hi_q`, `lo_q`, `gpio_out`.
- Reset mid-operation discards the in-flight WB instruction. The first post-reset edge captures the EX bundle normally.
- No combinational path from any `_EX` input to any output.

## Structure
- Shared package `mips_pkg`:
  - regsel constants `REGSEL_ALU`=0, `REGSEL_HI`=1, `REGSEL_LO`=2.
  - `WIDTH`/`RADDR` defaults.
  - The control-bundle typedef, shared with the decoder.
- Sub-module `hilo_reg`: HI/LO pair with enable and async active-low reset.
- Everything else is in the top level.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release, then ADD with `alu_lo_EX`=0x0000_0007, rd=8 → next cycle `regwrite_WB`=1, `writeaddr_WB`=8, `writedata_WB`=7.
- Back-to-back mult→mfhi→mflo:
  - mult with hi=0x1234_5678, lo=0x9ABC_DEF0.
  - mfhi rd=3 → `writedata_WB`=0x1234_5678.
  - mflo rd=4 → `writedata_WB`=0x9ABC_DEF0.
  - `regwrite_WB`=0 in the mult's WB cycle.
- $0 write: ADD to rd=0 with data 0xFFFF_FFFF → `regwrite_WB`=0.
- GPIO: gpio write with data 0xA5 → `gpio_out`=0xA5 next cycle and held through 5 subsequent non-GPIO instructions.
- Stall/flush:
  - mult (hi=1, lo=2) with `stall`=1 for 3 cycles → `hi_q`/`lo_q` and WB outputs unchanged throughout, update after release.
  - mult with `stall`=1 and `flush`=1 → bubble, HI/LO keep their old values.
- Async reset mid-stream: assert `rst`=0 between edges after HI=5 was written → `hi_q`=0 before the next edge.
